// File: rtl/serial_parallel_scatter_signed_16_outputs_if.sv
// Handshake bundle for the 16-lane signed scatter block: indexed input stream
// on one side, flattened vector with valid/ready on the other.
interface serial_parallel_scatter_signed_16_outputs_if #(
    parameter int WIDTH        = 8,
    parameter int ARGMAX_WIDTH = 8
);
    logic                      enable;
    logic                      in_valid;
    logic                      in_ready;
    logic [ARGMAX_WIDTH-1:0]   in_index;
    logic signed [WIDTH-1:0]   in_value;
    logic                      flush;
    logic [16*WIDTH-1:0]       out;
    logic [15:0]               out_mask;
    logic                      out_valid;
    logic                      out_ready;
    logic                      index_error;

    modport master (
        output enable, in_valid, in_index, in_value, flush, out_ready,
        input  in_ready, out, out_mask, out_valid, index_error
    );

    modport slave (
        input  enable, in_valid, in_index, in_value, flush, out_ready,
        output in_ready, out, out_mask, out_valid, index_error
    );
endinterface

// File: rtl/serial_parallel_scatter_signed_16_outputs.sv
// Scatters a serial (index, value) stream into a 16-lane signed vector and
// presents it once every lane is written or on an early flush.
module serial_parallel_scatter_signed_16_outputs #(
    parameter int WIDTH        = 8,
    parameter int ARGMAX_WIDTH = 8
) (
    input logic clk,
    input logic rst,
    serial_parallel_scatter_signed_16_outputs_if.slave bus
);
    typedef enum logic {FILL, HOLD} state_t;

    state_t                    state;
    logic [15:0][WIDTH-1:0]    lanes;
    logic [15:0]               mask;
    logic                      index_error_q;

    logic        accept;
    logic        index_ok;
    logic [3:0]  lane_sel;
    logic [15:0] new_bit;
    logic [15:0] next_mask;

    assign bus.in_ready    = bus.enable && (state == FILL);
    assign bus.out_valid   = (state == HOLD);
    assign bus.out         = lanes;
    assign bus.out_mask    = mask;
    assign bus.index_error = index_error_q;

    always_comb begin
        accept    = bus.in_valid && bus.in_ready;
        index_ok  = ((bus.in_index >> 4) == '0);
        lane_sel  = bus.in_index[3:0];
        new_bit   = '0;
        if (accept && index_ok)
            new_bit = 16'(1) << lane_sel;
        next_mask = mask | new_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FILL;
            lanes         <= '0;
            mask          <= '0;
            index_error_q <= 1'b0;
        end else begin
            index_error_q <= accept && !index_ok;
            case (state)
                FILL: begin
                    if (accept && index_ok) begin
                        lanes[lane_sel] <= bus.in_value;
                        mask            <= next_mask;
                    end
                    // A flush in the same cycle as an accept closes the vector including that write.
                    if ((next_mask == '1) ||
                        (bus.enable && bus.flush && (next_mask != '0)))
                        state <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        lanes <= '0;
                        mask  <= '0;
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_parallel_scatter_signed_16_outputs.sv
// Scoreboard bench: stimulus pushes expected vectors, a monitor pops and
// compares them on every output handshake.
module tb_serial_parallel_scatter_signed_16_outputs;
    localparam int W  = 8;
    localparam int AW = 8;

    typedef struct {
        logic [16*W-1:0] vec;
        logic [15:0]     mask;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    serial_parallel_scatter_signed_16_outputs_if #(.WIDTH(W), .ARGMAX_WIDTH(AW)) bus ();

    serial_parallel_scatter_signed_16_outputs #(.WIDTH(W), .ARGMAX_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called right after an active edge; returns #1 after the accepting edge.
    task automatic write(input int idx, input int val);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_index = AW'(idx);
        bus.in_value = W'(val);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL write_timeout: index %0d never accepted, in_ready=%b required 1", idx, bus.in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vector: got mask %h, required no output", bus.out_mask);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("vec_data", 128'(bus.out), 128'(e.vec));
                check("vec_mask", 128'(bus.out_mask), 128'(e.mask));
            end
        end
    end

    initial begin
        exp_t e;
        logic [16*W-1:0] held;

        rst = 1'b1;
        bus.enable = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_index = '0;
        bus.in_value = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state after idle
        repeat (3) @(negedge clk);
        check("rst_out", 128'(bus.out), 128'(0));
        check("rst_mask", 128'(bus.out_mask), 128'(0));
        check("rst_valid", 128'(bus.out_valid), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_index_error", 128'(bus.index_error), 128'(0));
        @(posedge clk); #1;

        // 2: lane i = i-8, full vector, immediate drain
        e.vec = '0;
        for (int i = 0; i < 16; i++) e.vec[i*W +: W] = W'(i - 8);
        e.mask = 16'hFFFF;
        sb.push_back(e);
        for (int i = 0; i < 16; i++) write(i, i - 8);
        bus.in_valid = 1'b0;
        check("full_lane0", 128'(bus.out[0 +: W]), 128'(8'hF8));
        check("full_lane15", 128'(bus.out[15*W +: W]), 128'(8'h07));
        @(posedge clk); #1;
        check("drain_valid", 128'(bus.out_valid), 128'(0));
        check("drain_out", 128'(bus.out), 128'(0));
        check("drain_mask", 128'(bus.out_mask), 128'(0));

        // 3: duplicate index then flush
        e.vec = '0;
        e.vec[3*W +: W] = 8'hF9;
        e.vec[9*W +: W] = 8'h7F;
        e.mask = 16'h0208;
        sb.push_back(e);
        write(3, 5);
        write(3, -7);
        write(9, 127);
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_valid", 128'(bus.out_valid), 128'(1));

        // 4: out-of-range index, then flush on empty mask
        write(20, 42);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("idx_err_pulse", 128'(bus.index_error), 128'(1));
        check("idx_err_mask", 128'(bus.out_mask), 128'(0));
        check("idx_err_out", 128'(bus.out), 128'(0));
        @(negedge clk);
        check("idx_err_clear", 128'(bus.index_error), 128'(0));
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("empty_flush_valid", 128'(bus.out_valid), 128'(0));
        check("empty_flush_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;

        // 5: backpressure on a full vector
        bus.out_ready = 1'b0;
        e.vec = '0;
        for (int i = 0; i < 16; i++) e.vec[i*W +: W] = W'(3*i - 20);
        e.mask = 16'hFFFF;
        sb.push_back(e);
        for (int i = 0; i < 16; i++) write(15 - i, 3*(15 - i) - 20);
        bus.in_index = 8'd0;
        bus.in_value = 8'h55;
        held = e.vec;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 128'(bus.out_valid), 128'(1));
            check("bp_in_ready", 128'(bus.in_ready), 128'(0));
            check("bp_out_stable", 128'(bus.out), 128'(held));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_resume_ready", 128'(bus.in_ready), 128'(1));
        check("bp_resume_valid", 128'(bus.out_valid), 128'(0));
        @(posedge clk); #1;

        // 6: async reset mid-fill, then clean refill
        for (int i = 0; i < 8; i++) write(i, i + 1);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_mask", 128'(bus.out_mask), 128'(0));
        check("async_rst_out", 128'(bus.out), 128'(0));
        check("async_rst_valid", 128'(bus.out_valid), 128'(0));
        @(posedge clk); #1 rst = 1'b0;
        e.vec = '0;
        for (int i = 0; i < 16; i++) e.vec[i*W +: W] = W'(100 - i);
        e.mask = 16'hFFFF;
        sb.push_back(e);
        for (int i = 0; i < 16; i++) write(i, 100 - i);
        bus.in_valid = 1'b0;

        for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("scoreboard_empty", 128'(sb.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_parallel_scatter_signed_16_outputs.md
Name: serial_parallel_scatter_signed_16_outputs

Overview:
- Inverse of the 16-input signed argmax: accepts a serial stream of (index, value) pairs and scatters each value into lane `index` of a 16-lane signed vector.
- Presents the assembled vector on a valid/ready output once all 16 lanes are written, or early on flush.
- Sits between the argmax/selection stage and downstream parallel consumers: rebuilds per-lane vectors from sparse indexed results, e.g. for test vector generation or winner-take-all masks.

Parameters:
- WIDTH, 8, signed lane value width in bits.
- ARGMAX_WIDTH, 8, index width in bits; must be >= 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  when low, the block accepts no input and ignores flush; an output handshake in progress still completes.
- in_valid  input  1  input pair valid.
- in_ready  output  1  block can accept a pair this cycle; combinational = enable && state==FILL.
- in_index  input  ARGMAX_WIDTH  target lane.
- in_value  input signed  WIDTH  value to write.
- flush  input  1  close the current vector early.
- out  output  16*WIDTH  flattened vector; lane i at [i*WIDTH +: WIDTH], signed two's complement.
- out_mask  output  16  bit i set = lane i written since last drain.
- out_valid  output  1  vector presented; high exactly when state==HOLD.
- out_ready  input  1  downstream consumes vector.
- index_error  output  1  registered one-cycle pulse after an accepted pair with in_index >= 16.

Behaviour:
- Reset (async, rst=1):
  - all lanes 0, out_mask 0, state FILL, index_error 0;
  - out_valid 0 immediately; in_ready follows enable.
  - Reset mid-fill or mid-hold discards everything.
- State FILL:
  - Accept occurs when in_valid && in_ready.
  - Accept with index < 16: lane[index] <= in_value and mask[index] <= 1.
  - Duplicate index: overwrite, last write wins; the mask bit is already 1.
  - Accept with index >= 16 (any bit above [3:0] set): no lane/mask change; index_error = 1 in the next cycle only.
  - Going to HOLD:
    - move to HOLD at the edge where (mask | new bit) == 16'hFFFF;
    - or at the edge where enable && flush && (mask | new bit) != 0;
    - a flush together with an accept includes that accepted write.
  - Flush with empty mask and no valid write: ignored, stay in FILL.
- State HOLD:
  - out_valid=1; out and out_mask stable; in_ready=0; flush ignored.
  - When out_ready=1: at the edge, clear all lanes to 0 and mask to 0, and return to FILL.
  - At least one bubble cycle exists between the drain and the next accept.
- Latency: a write accepted at edge N is visible on out/out_mask after edge N. If it completes the vector, out_valid=1 in the cycle following edge N.
- Throughput: 16 pairs per 16 cycles in FILL, plus 1 drain cycle minimum per vector.
- Arithmetic: values are stored bit-exact, with no extension or saturation.
- out_mask reflects the current partial fill also during FILL.
- enable low in FILL: state, lanes and mask frozen; in_ready=0.

Test Plan:
1. Reset, then idle 3 cycles -> out=0, out_mask=0, out_valid=0, in_ready=1, index_error=0.
2. Write index i, value i-8 for i=0..15 back-to-back, out_ready=1 -> out_valid=1 the cycle after the 16th accept; lane0=-8, lane15=7, out_mask=16'hFFFF. One cycle later out_valid=0, lanes 0, mask 0.
3. Write (3,5), (3,-7), (9,127), then flush -> HOLD with lane3=-7, lane9=127, all other lanes 0, out_mask=16'h0208.
4. Write (20,42) -> index_error=1 for exactly one cycle; mask/lanes unchanged. Flush on empty mask afterwards -> stays in FILL, out_valid=0.
5. Fill all 16 lanes, hold out_ready=0 for 5 cycles -> out_valid stays 1, out stable, in_ready=0 even with in_valid=1. Then out_ready=1 -> drain; accepts resume on the following cycle.
6. Write 8 pairs, assert rst asynchronously between edges -> out_mask=0 and out=0 immediately. After release, a full 16-write sequence produces correct vector (lane i = 100-i).
